// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: baud divisor, data width and optional parity,
// with false-start rejection and parity / framing / overrun status.
module uart_rx_cfg #(
   parameter int BAUD_DIV   = 2604,
   parameter int DATA_BITS  = 8,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 RX,
   input  logic                 clr_rdy,
   output logic                 rdy,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun
);

   localparam int CW = $clog2(BAUD_DIV);
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam logic [CW-1:0] HALF_LOAD = CW'(BAUD_DIV / 2 - 1);
   localparam logic [CW-1:0] FULL_LOAD = CW'(BAUD_DIV - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [BW-1:0] BIT_ONE   = BW'(1);
   localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t                state_q, state_d;
   logic                  rx_s1_q, rx_s2_q, rx_s3_q;
   logic [CW-1:0]         baud_cnt_q, baud_cnt_d;
   logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0]  shift_q, shift_d;
   logic                  par_bit_q, par_bit_d;
   logic                  rdy_q, rdy_d;
   logic [DATA_BITS-1:0]  rx_data_q, rx_data_d;
   logic                  parity_err_q, parity_err_d;
   logic                  frame_err_q, frame_err_d;
   logic                  overrun_q, overrun_d;
   logic                  fall_s;
   logic                  sample_s;

   // Error when the data bits plus received parity bit do not XOR to the selected sense.
   function automatic logic calc_parity_err(input logic [DATA_BITS-1:0] d, input logic p);
      return (^{d, p}) != PARITY_ODD[0];
   endfunction

   assign fall_s   = rx_s3_q & ~rx_s2_q;
   assign sample_s = (state_q != S_IDLE) && (baud_cnt_q == {CW{1'b0}});

   // Next-state, counter and status computation.
   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      par_bit_d    = par_bit_q;
      rx_data_d    = rx_data_q;
      parity_err_d = parity_err_q;
      frame_err_d  = frame_err_q;
      if (clr_rdy) begin
         rdy_d     = 1'b0;
         overrun_d = 1'b0;
      end else begin
         rdy_d     = rdy_q;
         overrun_d = overrun_q;
      end
      if (state_q == S_IDLE) begin
         baud_cnt_d = baud_cnt_q;
      end else if (sample_s) begin
         baud_cnt_d = FULL_LOAD;
      end else begin
         baud_cnt_d = baud_cnt_q - CNT_ONE;
      end
      case (state_q)
         S_IDLE: begin
            if (fall_s) begin
               state_d    = S_START;
               baud_cnt_d = HALF_LOAD;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_START: begin
            if (sample_s && rx_s2_q) begin
               state_d = S_IDLE;
            end else if (sample_s) begin
               bit_cnt_d = {BW{1'b0}};
               state_d   = S_DATA;
            end else begin
               state_d = S_START;
            end
         end
         S_DATA: begin
            if (sample_s) begin
               shift_d   = {rx_s2_q, shift_q[DATA_BITS-1:1]};
               bit_cnt_d = bit_cnt_q + BIT_ONE;
               if (bit_cnt_q == LAST_BIT) begin
                  state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
               end else begin
                  state_d = S_DATA;
               end
            end else begin
               state_d = S_DATA;
            end
         end
         S_PARITY: begin
            if (sample_s) begin
               par_bit_d = rx_s2_q;
               state_d   = S_STOP;
            end else begin
               state_d = S_PARITY;
            end
         end
         S_STOP: begin
            // Leave at mid-stop so a back-to-back start edge is not missed.
            if (sample_s) begin
               state_d      = S_IDLE;
               rx_data_d    = shift_q;
               frame_err_d  = ~rx_s2_q;
               parity_err_d = (PARITY_EN != 0) ? calc_parity_err(shift_q, par_bit_q) : 1'b0;
               rdy_d        = 1'b1;
               overrun_d    = rdy_q & ~clr_rdy;
            end else begin
               state_d = S_STOP;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, synchroniser and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         rx_s1_q      <= 1'b1;
         rx_s2_q      <= 1'b1;
         rx_s3_q      <= 1'b1;
         baud_cnt_q   <= {CW{1'b0}};
         bit_cnt_q    <= {BW{1'b0}};
         shift_q      <= {DATA_BITS{1'b0}};
         par_bit_q    <= 1'b0;
         rdy_q        <= 1'b0;
         rx_data_q    <= {DATA_BITS{1'b0}};
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         rx_s1_q      <= RX;
         rx_s2_q      <= rx_s1_q;
         rx_s3_q      <= rx_s2_q;
         baud_cnt_q   <= baud_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         par_bit_q    <= par_bit_d;
         rdy_q        <= rdy_d;
         rx_data_q    <= rx_data_d;
         parity_err_q <= parity_err_d;
         frame_err_q  <= frame_err_d;
         overrun_q    <= overrun_d;
      end
   end

   assign rdy        = rdy_q;
   assign rx_data    = rx_data_q;
   assign parity_err = parity_err_q;
   assign frame_err  = frame_err_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: an 8N1 instance and a 7E1 instance, checked every cycle
// against a frame-level model plus literal expectations.
module tb_uart_rx_cfg;

   localparam int BD = 16;

   typedef struct {
      int         edge_n;
      int         which;
      logic [8:0] data;
      logic       perr;
      logic       ferr;
   } frame_t;

   logic       clk = 1'b0;
   logic       rst_n, clr_rdy, rx8, rx7;
   logic       rdy8, perr8, ferr8, ovr8;
   logic       rdy7, perr7, ferr7, ovr7;
   logic [7:0] data8;
   logic [6:0] data7;

   int     cyc = 0;
   int     qh = 0;
   frame_t q[$];
   logic       exp_rdy  [2];
   logic       exp_ovr  [2];
   logic       exp_perr [2];
   logic       exp_ferr [2];
   logic [8:0] exp_data [2];

   int   checks, failures;
   int   last_fall, rise8;
   logic chk_en;

   always #5 clk = ~clk;

   uart_rx_cfg #(.BAUD_DIV(BD), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .RX(rx8), .clr_rdy(clr_rdy), .rdy(rdy8),
      .rx_data(data8), .parity_err(perr8), .frame_err(ferr8), .overrun(ovr8));

   uart_rx_cfg #(.BAUD_DIV(BD), .DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(0)) u_dut7 (
      .clk(clk), .rst_n(rst_n), .RX(rx7), .clr_rdy(clr_rdy), .rdy(rdy7),
      .rx_data(data7), .parity_err(perr7), .frame_err(ferr7), .overrun(ovr7));

   // Frame-level model: each queued frame completes at its precomputed edge.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            exp_rdy[i]  <= 1'b0;
            exp_ovr[i]  <= 1'b0;
            exp_perr[i] <= 1'b0;
            exp_ferr[i] <= 1'b0;
            exp_data[i] <= 9'h000;
         end
         qh <= q.size();
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (qh < q.size() && q[qh].edge_n == cyc + 1 && q[qh].which == i) begin
               exp_rdy[i]  <= 1'b1;
               exp_ovr[i]  <= exp_rdy[i] & ~clr_rdy;
               exp_data[i] <= q[qh].data;
               exp_perr[i] <= q[qh].perr;
               exp_ferr[i] <= q[qh].ferr;
            end else if (clr_rdy) begin
               exp_rdy[i] <= 1'b0;
               exp_ovr[i] <= 1'b0;
            end
         end
         if (qh < q.size() && q[qh].edge_n == cyc + 1) qh <= qh + 1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         failures = failures + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic set_rx(input int which, input logic v);
      if (which == 0) rx8 = v;
      else rx7 = v;
   endtask

   // Sends one frame (start, data LSB first, optional parity, stop) and queues its outcome.
   task automatic send_frame(input int which, input logic [8:0] data, input logic par_bit,
                             input logic stop_bit);
      int         nb, pe, ones;
      logic [8:0] mask;
      frame_t     f;
      nb   = (which == 0) ? 8 : 7;
      pe   = (which == 0) ? 0 : 1;
      mask = (which == 0) ? 9'h0FF : 9'h07F;
      ones = (pe != 0) ? int'(par_bit) : 0;
      for (int i = 0; i < nb; i++) ones += int'(data[i]);
      @(negedge clk);
      last_fall = cyc + 1;
      f.edge_n  = last_fall + BD / 2 + (nb + pe + 1) * BD + 2;
      f.which   = which;
      f.data    = data & mask;
      f.perr    = (pe != 0) && ((ones % 2) != 0);
      f.ferr    = ~stop_bit;
      q.push_back(f);
      set_rx(which, 1'b0);
      repeat (BD) @(negedge clk);
      for (int i = 0; i < nb; i++) begin
         set_rx(which, data[i]);
         repeat (BD) @(negedge clk);
      end
      if (pe != 0) begin
         set_rx(which, par_bit);
         repeat (BD) @(negedge clk);
      end
      set_rx(which, stop_bit);
      repeat (BD) @(negedge clk);
   endtask

   task automatic pulse_clr();
      clr_rdy = 1'b1;
      @(negedge clk);
      clr_rdy = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; clr_rdy = 1'b0; rx8 = 1'b1; rx7 = 1'b1;
      chk_en = 1'b0; checks = 0; failures = 0; last_fall = 0; rise8 = 0;

      fork
         begin : compare
            logic       prev8;
            logic [12:0] act, exp;
            prev8 = 1'b0;
            forever begin
               @(negedge clk);
               if (chk_en) begin
                  act = {rdy8, ovr8, ferr8, perr8, 1'b0, data8};
                  exp = {exp_rdy[0], exp_ovr[0], exp_ferr[0], exp_perr[0], exp_data[0]};
                  checks = checks + 1;
                  if (act !== exp) begin
                     failures = failures + 1;
                     $display("FAIL cycle_dut8 cyc=%0d: got %h expected %h", cyc, act, exp);
                  end
                  act = {rdy7, ovr7, ferr7, perr7, 2'b00, data7};
                  exp = {exp_rdy[1], exp_ovr[1], exp_ferr[1], exp_perr[1], exp_data[1]};
                  checks = checks + 1;
                  if (act !== exp) begin
                     failures = failures + 1;
                     $display("FAIL cycle_dut7 cyc=%0d: got %h expected %h", cyc, act, exp);
                  end
               end
               if (rdy8 === 1'b1 && prev8 === 1'b0) rise8 = cyc;
               prev8 = rdy8;
            end
         end
      join_none

      repeat (3) @(negedge clk);
      chk("reset_rdy", {31'd0, rdy8}, 32'd0);
      chk("reset_data", {24'd0, data8}, 32'd0);
      chk("reset_flags", {29'd0, perr8, ferr8, ovr8}, 32'd0);
      rst_n  = 1'b1;
      chk_en = 1'b1;
      repeat (5) @(negedge clk);

      // Basic 8N1
      send_frame(0, 9'h0A5, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      chk("basic_data", {24'd0, data8}, 32'h0000_00A5);
      chk("basic_rdy", {31'd0, rdy8}, 32'd1);
      chk("basic_flags", {29'd0, perr8, ferr8, ovr8}, 32'd0);
      chk("basic_latency", rise8 - last_fall, 32'd154);
      pulse_clr();
      chk("basic_clr", {31'd0, rdy8}, 32'd0);

      // 7 data bits, even parity
      send_frame(1, 9'h041, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      chk("par_ok_err", {31'd0, perr7}, 32'd0);
      chk("par_ok_data", {25'd0, data7}, 32'h41);
      pulse_clr();
      send_frame(1, 9'h041, 1'b1, 1'b1);
      repeat (4) @(negedge clk);
      chk("par_bad_err", {31'd0, perr7}, 32'd1);
      chk("par_bad_data", {25'd0, data7}, 32'h41);
      pulse_clr();

      // Framing error, then line held low
      send_frame(0, 9'h03C, 1'b0, 1'b0);
      repeat (4) @(negedge clk);
      chk("frame_err", {31'd0, ferr8}, 32'd1);
      chk("frame_rdy", {31'd0, rdy8}, 32'd1);
      pulse_clr();
      repeat (40 * BD) @(negedge clk);
      chk("hold_low_no_rdy", {31'd0, rdy8}, 32'd0);
      rx8 = 1'b1;
      repeat (2 * BD) @(negedge clk);
      send_frame(0, 9'h055, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      chk("after_hold_data", {24'd0, data8}, 32'h55);
      chk("after_hold_ferr", {31'd0, ferr8}, 32'd0);
      pulse_clr();

      // Short low glitch on the line
      rx8 = 1'b0;
      repeat (3) @(negedge clk);
      rx8 = 1'b1;
      repeat (40) @(negedge clk);
      chk("glitch_no_rdy", {31'd0, rdy8}, 32'd0);
      send_frame(0, 9'h081, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      chk("glitch_next_data", {24'd0, data8}, 32'h81);
      pulse_clr();

      // Back-to-back overrun, then acknowledge in the completion cycle
      send_frame(0, 9'h011, 1'b0, 1'b1);
      send_frame(0, 9'h022, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      chk("ovr_data", {24'd0, data8}, 32'h22);
      chk("ovr_flag", {31'd0, ovr8}, 32'd1);
      fork
         send_frame(0, 9'h033, 1'b0, 1'b1);
      join_none
      @(negedge clk);
      repeat (154) @(negedge clk);
      clr_rdy = 1'b1;
      @(negedge clk);
      clr_rdy = 1'b0;
      chk("simul_rdy", {31'd0, rdy8}, 32'd1);
      chk("simul_ovr", {31'd0, ovr8}, 32'd0);
      chk("simul_data", {24'd0, data8}, 32'h33);
      repeat (20) @(negedge clk);

      // Reset while the fifth data bit of 0xF0 is on the line
      fork
         send_frame(0, 9'h0F0, 1'b0, 1'b1);
      join_none
      @(negedge clk);
      repeat (86) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_rdy", {31'd0, rdy8}, 32'd0);
      chk("midrst_data", {24'd0, data8}, 32'd0);
      chk("midrst_flags", {29'd0, perr8, ferr8, ovr8}, 32'd0);
      rst_n = 1'b1;
      repeat (100) @(negedge clk);
      chk("midrst_no_rdy", {31'd0, rdy8}, 32'd0);
      send_frame(0, 9'h00F, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      chk("after_rst_data", {24'd0, data8}, 32'h0F);
      chk("after_rst_rdy", {31'd0, rdy8}, 32'd1);

      repeat (4) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
